// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed seven-segment scan driver with frame-coherent shadow
// registers, per-digit dead time, blanking, decimal points and leading-zero suppression.
// Latency: all outputs registered, one cycle after the cnt/idx/shadow state they reflect.
// Backpressure: none; free-running scan, inputs sampled only at frame boundaries.
//
// Ports:
//   ssd_scan_driver_port_clk   - clock, all state on rising edge
//   ssd_scan_driver_port_rst   - synchronous active-high reset
//   ssd_scan_driver_port_inp   - hex nibbles, nibble k -> digit k (digit 0 = LSD)
//   ssd_scan_driver_port_dp    - decimal point request per digit (1 = lit)
//   ssd_scan_driver_port_blank - force digit dark (1 = dark)
//   ssd_scan_driver_port_lz_en - leading-zero suppression enable (live, not shadowed)
//   ssd_scan_driver_port_cc    - segments a..g on bits 6..0, active-low
//   ssd_scan_driver_port_dp_n  - decimal point, active-low
//   ssd_scan_driver_port_an    - digit enables, active-low, at most one low
//   ssd_scan_driver_port_frame - one-cycle pulse at each frame start
module ssd_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 2
) (
  input  logic                    ssd_scan_driver_port_clk,
  input  logic                    ssd_scan_driver_port_rst,
  input  logic [4*N_DIGITS-1:0]   ssd_scan_driver_port_inp,
  input  logic [N_DIGITS-1:0]     ssd_scan_driver_port_dp,
  input  logic [N_DIGITS-1:0]     ssd_scan_driver_port_blank,
  input  logic                    ssd_scan_driver_port_lz_en,
  output logic [6:0]              ssd_scan_driver_port_cc,
  output logic                    ssd_scan_driver_port_dp_n,
  output logic [N_DIGITS-1:0]     ssd_scan_driver_port_an,
  output logic                    ssd_scan_driver_port_frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] val_s;
  logic [N_DIGITS-1:0]   dp_s;
  logic [N_DIGITS-1:0]   blank_s;
  logic                  load_pend;  // set by reset: forces a shadow load on the first edge after release

  logic                  cnt_wrap;
  logic                  load;
  logic                  dead;
  logic                  dark;
  logic                  supp;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   tail_zero;  // tail_zero[k]: nibbles k..N_DIGITS-1 all zero
  logic [N_DIGITS-1:0]   an_lit;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    logic acc;
    acc       = 1'b1;
    tail_zero = '0;
    // Scan from the most significant digit down, accumulating "all zero so far".
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc          = acc && (val_s[4*k +: 4] == 4'h0);
      tail_zero[k] = acc;
    end
  end

  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    // Frame-end load keeps a whole frame on one snapshot of the inputs.
    load     = load_pend || (cnt_wrap && (idx == IDX_LAST));
    dead     = (DEAD_CYC > 0) && (cnt < DEAD_LIM);
    dark     = dead || blank_s[idx];
    supp     = ssd_scan_driver_port_lz_en && (idx != '0) && tail_zero[idx];
    nib      = val_s[{idx, 2'b00} +: 4];
    an_lit   = ~(N_DIGITS'(1) << idx);
  end

  always_ff @(posedge ssd_scan_driver_port_clk) begin
    if (ssd_scan_driver_port_rst) begin
      cnt                        <= '0;
      idx                        <= '0;
      val_s                      <= '0;
      dp_s                       <= '0;
      blank_s                    <= '1;
      load_pend                  <= 1'b1;
      ssd_scan_driver_port_cc    <= 7'h7F;
      ssd_scan_driver_port_dp_n  <= 1'b1;
      ssd_scan_driver_port_an    <= '1;
      ssd_scan_driver_port_frame <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        val_s     <= ssd_scan_driver_port_inp;
        dp_s      <= ssd_scan_driver_port_dp;
        blank_s   <= ssd_scan_driver_port_blank;
        load_pend <= 1'b0;
      end
      ssd_scan_driver_port_an    <= dead ? '1 : an_lit;
      ssd_scan_driver_port_cc    <= (dark || supp) ? 7'h7F : seg7(nib);
      ssd_scan_driver_port_dp_n  <= dark ? 1'b1 : ~dp_s[idx];
      // cnt==0 && idx==0 marks the first cycle of a frame, including the
      // first cycle after reset release.
      ssd_scan_driver_port_frame <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of the scan driver with N_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1.
// Latency: outputs sampled on the falling edge, reflecting the preceding rising edge.
// Backpressure: none.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inp;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [6:0]  cc;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int errors = 0;
  logic mon_en  = 1'b0;
  logic frame_q = 1'b0;

  localparam logic [6:0] S_0   = 7'b0000001;
  localparam logic [6:0] S_1   = 7'b1001111;
  localparam logic [6:0] S_2   = 7'b0010010;
  localparam logic [6:0] S_5   = 7'b0100100;
  localparam logic [6:0] S_7   = 7'b0001111;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_F   = 7'b0111000;
  localparam logic [6:0] S_OFF = 7'b1111111;

  ssd_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYC(1)) dut (
    .ssd_scan_driver_port_clk   (clk),
    .ssd_scan_driver_port_rst   (rst),
    .ssd_scan_driver_port_inp   (inp),
    .ssd_scan_driver_port_dp    (dp),
    .ssd_scan_driver_port_blank (blank),
    .ssd_scan_driver_port_lz_en (lz_en),
    .ssd_scan_driver_port_cc    (cc),
    .ssd_scan_driver_port_dp_n  (dp_n),
    .ssd_scan_driver_port_an    (an),
    .ssd_scan_driver_port_frame (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One digit slot: a dead cycle then three lit cycles of digit k.
  task automatic slot(input int k, input logic [6:0] exp_cc, input logic exp_dpn);
    logic [3:0] one;
    logic [3:0] exp_an;
    one    = 4'b0001;
    exp_an = ~(one << k);
    @(negedge clk);
    chk($sformatf("dead_an_d%0d", k), an, 4'hF);
    chk($sformatf("dead_cc_d%0d", k), cc, S_OFF);
    chk($sformatf("dead_dpn_d%0d", k), dp_n, 1'b1);
    chk($sformatf("dead_frame_d%0d", k), frame, (k == 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lit_an_d%0d_c%0d", k, c), an, exp_an);
      chk($sformatf("lit_cc_d%0d_c%0d", k, c), cc, exp_cc);
      chk($sformatf("lit_dpn_d%0d_c%0d", k, c), dp_n, exp_dpn);
      chk($sformatf("lit_frame_d%0d_c%0d", k, c), frame, 1'b0);
    end
  endtask

  // Continuous properties: one-hot-or-zero anodes, no back-to-back frame pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(~an)) else begin
        errors++;
        $error("FAIL an_onehot observed=%b expected=at_most_one_low", an);
      end
      checks++;
      assert (!(frame && frame_q)) else begin
        errors++;
        $error("FAIL frame_width observed=%b%b expected=not_11", frame_q, frame);
      end
      frame_q = frame;
    end
  end

  initial begin
    rst   = 1'b1;
    inp   = 16'h12AF;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_cc", cc, S_OFF);
    chk("rst_dpn", dp_n, 1'b1);
    chk("rst_frame", frame, 1'b0);
    mon_en = 1'b1;
    rst    = 1'b0;

    // Frame 1: 12AF; switch inputs to 0000 mid-frame.
    slot(0, S_F, 1'b1);
    slot(1, S_A, 1'b1);
    inp = 16'h0000;
    slot(2, S_2, 1'b1);
    slot(3, S_1, 1'b1);

    // Frame 2: 0000 without suppression; stage 0007 for the next frame.
    slot(0, S_0, 1'b1);
    slot(1, S_0, 1'b1);
    inp = 16'h0007;
    slot(2, S_0, 1'b1);
    slot(3, S_0, 1'b1);
    lz_en = 1'b1;

    // Frame 3: 0007 with suppression.
    slot(0, S_7, 1'b1);
    slot(1, S_OFF, 1'b1);
    inp = 16'h0000;
    slot(2, S_OFF, 1'b1);
    slot(3, S_OFF, 1'b1);

    // Frame 4: 0000 with suppression -> digit 0 still shows 0.
    slot(0, S_0, 1'b1);
    slot(1, S_OFF, 1'b1);
    inp   = 16'h0500;
    dp    = 4'b0100;
    blank = 4'b0100;
    slot(2, S_OFF, 1'b1);
    slot(3, S_OFF, 1'b1);

    // Frame 5: 0500, digit 2 blanked (dp suppressed too), digit 1 is an embedded zero.
    slot(0, S_0, 1'b1);
    slot(1, S_0, 1'b1);
    blank = 4'b0000;
    slot(2, S_OFF, 1'b1);
    slot(3, S_OFF, 1'b1);

    // Frame 6: digit 2 unblanked, decimal point lit.
    slot(0, S_0, 1'b1);
    slot(1, S_0, 1'b1);
    slot(2, S_5, 1'b0);
    slot(3, S_OFF, 1'b1);

    // Frame 7: reset pulse partway through digit 2.
    slot(0, S_0, 1'b1);
    slot(1, S_0, 1'b1);
    @(negedge clk);
    chk("pre_rst_an", an, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", an, 4'hF);
    chk("midrst_cc", cc, S_OFF);
    chk("midrst_dpn", dp_n, 1'b1);
    chk("midrst_frame", frame, 1'b0);
    rst = 1'b0;

    // Scan restarts at digit 0 with a frame pulse.
    slot(0, S_0, 1'b1);
    slot(1, S_0, 1'b1);
    slot(2, S_5, 1'b0);
    slot(3, S_OFF, 1'b1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 The block SHALL be parametrised as follows, one per line: name, default, meaning.
- N_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; minimum 4.
- DEAD_CYC, 2, cycles at the start of each slot with all anodes off; range 0..REFRESH_DIV-2.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning. It uses one clock; reset is synchronous and active-high.
- ssd_scan_driver_port_clk, in, 1, sole clock; all state on the rising edge.
- ssd_scan_driver_port_rst, in, 1, synchronous active-high reset.
- ssd_scan_driver_port_inp, in, 4*N_DIGITS, hex nibbles; nibble k drives digit k; digit 0 is least significant.
- ssd_scan_driver_port_dp, in, N_DIGITS, decimal point request per digit; 1 = lit.
- ssd_scan_driver_port_blank, in, N_DIGITS, force digit k dark; 1 = dark.
- ssd_scan_driver_port_lz_en, in, 1, leading-zero suppression enable.
- ssd_scan_driver_port_cc, out, 7, segments a..g on bits 6..0; active-low.
- ssd_scan_driver_port_dp_n, out, 1, decimal point; active-low.
- ssd_scan_driver_port_an, out, N_DIGITS, digit enables; active-low; at most one bit low.
- ssd_scan_driver_port_frame, out, 1, one-cycle pulse at each frame start.

Function
REQ-003 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; the digit index idx SHALL advance by 1 on every cnt wrap, going from N_DIGITS-1 to 0.
REQ-004 The shadow registers (value, dp, blank) SHALL load from the inputs:
- in the cycle where cnt==REFRESH_DIV-1 and idx==N_DIGITS-1, and
- on the first clock edge after reset deasserts.
At all other times the inputs SHALL be ignored, so that no frame tears.
REQ-005 All outputs SHALL be registered and computed from the cnt, idx and shadow values present before the clock edge, giving one cycle of latency.
REQ-006 The an output SHALL be all ones when cnt<DEAD_CYC; otherwise bit idx SHALL be 0 and all other bits 1.
REQ-007 The cc output SHALL use the active-low code table below, covering nibbles 0..F in order:
- 0000001, 1001111, 0010010, 0000110,
- 1001100, 0100100, 0100000, 0001111,
- 0000000, 0000100, 0001000, 1100000,
- 0110001, 1000010, 0110000, 0111000.
REQ-008 The cc output SHALL be 1111111 when:
- shadow blank[idx]==1, or
- the digit is leading-zero suppressed, or
- an is all ones (dead time).
REQ-009 A digit k SHALL be leading-zero suppressed when all of the following hold:
- lz_en==1,
- k>0,
- shadow nibbles k..N_DIGITS-1 are all zero.
Digit 0 SHALL never be suppressed; lz_en SHALL be sampled live, not shadowed.
REQ-010 The dp_n output SHALL equal ~shadow dp[idx], independent of suppression, and SHALL be 1 when blank[idx]==1 or during dead time.
REQ-011 The frame output SHALL be 1 for exactly one cycle: the cycle after the edge on which idx wraps to 0, and also the first cycle after the reset-release shadow load.
REQ-012 The widths of cnt and idx SHALL be derived from the parameters with $clog2, with a minimum of 1 bit; no arithmetic overflow SHALL be possible for legal parameters.
REQ-013 When N_DIGITS==1, idx SHALL stay 0 and the shadow SHALL load on every cnt wrap.

Reset
REQ-014 While rst==1, the state SHALL be forced as follows:
- cnt=0, idx=0;
- shadow value=0, shadow dp=0, shadow blank=all ones;
- cc=1111111, dp_n=1, an=all ones, frame=0.
REQ-015 A reset asserted mid-frame SHALL take effect at the next edge, abandoning the current slot; no partial frame SHALL follow release.

Verification
REQ-016 The bench SHALL use N_DIGITS=4, REFRESH_DIV=4 and DEAD_CYC=1, and SHALL cover the following scenarios:
- Reset then release with inp=16'h12AF and lz_en=0 -> frame=1 on the first cycle. The scan sequence is then an=1111 for 1 cycle, then 1110 with cc=0111000 for 3 cycles, then digits 1..3 showing A, 2, 1 with their an bits low. Each slot is 4 cycles long, and frame recurs every 16 cycles.
- inp is changed from 16'h12AF to 16'h0000 mid-frame -> the remaining digits of that frame still show 12AF values; 0000 appears only from the next frame.
- inp=16'h0007 with lz_en=1 -> digits 3..1 show cc=1111111; digit 0 shows 0001111. The same stimulus with inp=16'h0000 shows digit 0 as 0000001.
- dp=4'b0100 with blank=4'b0100 -> digit 2 shows cc=1111111 and dp_n=1; with blank=0, digit 2 shows dp_n=0.
- rst is pulsed for one cycle while idx==2 -> the next edge gives an=1111, cc=1111111 and frame=0. After release, the scan restarts at digit 0 with frame=1.
- Assertion throughout all scenarios: an is never low in more than one bit, and frame is never high for two consecutive cycles.
